pipelined_adder_nbit: RTL and testbench

//   Parametrised, carry-pipelined N-bit adder with carry-in, carry-out and

---
 rtl/pipelined_adder_nbit.sv | 106 ++++++++++
 tb/tb_pipelined_adder_nbit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_nbit.sv
// Purpose: carry-pipelined WIDTH-bit adder (A + B + Cin) with Cout and signed overflow.
// Latency: STAGES cycles; a result accepted on edge n is presented after edge n+STAGES-1.
// Backpressure: the whole pipe stalls when out_valid && !out_ready; in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid/in_ready        input handshake for A, B, Cin
//   A, B [WIDTH], Cin        operands and carry-in to bit 0
//   out_valid/out_ready      output handshake for Sum, Cout, Ovf
//   Sum [WIDTH], Cout, Ovf   registered result, carry-out, two's-complement overflow
module pipelined_adder_nbit #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int C = WIDTH / STAGES;  // chunk width added per stage
  localparam int L = STAGES - 1;      // index of the output stage

  logic advance;

  // Registered per-stage state. a_q/b_q hold the operand chunks not yet
  // consumed, shifted down so the next stage always reads bits [C-1:0].
  // s_q accumulates finished chunks from the top down, so after the last
  // stage chunk 0 has been shifted into bits [C-1:0].
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              ovf_q;

  // Per-stage inputs and chunk sums (combinational).
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] c_d;
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [C:0]        add_d [STAGES];
  logic              ovf_d;

  assign advance   = !vld_q[L] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[L];
  assign Sum       = s_q[L];
  assign Cout      = c_q[L];
  assign Ovf       = ovf_q;

  always_comb begin
    v_d = '0;
    c_d = '0;
    // Stage 0 is fed straight from the input port.
    v_d[0] = in_valid;
    c_d[0] = Cin;
    a_d[0] = A;
    b_d[0] = B;
    s_d[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = vld_q[k-1];
      c_d[k] = c_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_d[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      add_d[k] = {1'b0, a_d[k][C-1:0]} + {1'b0, b_d[k][C-1:0]} + {{C{1'b0}}, c_d[k]};
    end
    // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ carry_in = sum.
    ovf_d = (a_d[L][C-1] ^ b_d[L][C-1] ^ add_d[L][C-1]) ^ add_d[L][C];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= v_d[k];
        c_q[k]   <= add_d[k][C];
        a_q[k]   <= a_d[k] >> C;
        b_q[k]   <= b_d[k] >> C;
        s_q[k]   <= (s_d[k] >> C) | (WIDTH'(add_d[k][C-1:0]) << (WIDTH - C));
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Purpose: self-checking bench for pipelined_adder_nbit; directed tests on (8,2), random sweep on five configs.
// Latency: expectations follow STAGES-cycle latency; sweep results are matched in acceptance order.
// Backpressure: sweep drives random out_ready; directed test holds out_ready low for 5 cycles.
module tb_pipelined_adder_nbit;

  localparam int ND = 5;
  localparam int W [ND] = '{8, 8, 8, 16, 32};

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;

  logic [ND-1:0] ir, ov, co, of;
  logic [31:0]   sm [ND];
  logic [7:0]    s0, s1, s2;
  logic [15:0]   s3;
  logic [31:0]   s4;

  int passed = 0;
  int total  = 0;

  assign sm[0] = {24'd0, s0};
  assign sm[1] = {24'd0, s1};
  assign sm[2] = {24'd0, s2};
  assign sm[3] = {16'd0, s3};
  assign sm[4] = s4;

  pipelined_adder_nbit #(.WIDTH(8), .STAGES(2)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .A(a[7:0]), .B(b[7:0]), .Cin(cin),
    .out_valid(ov[0]), .out_ready(out_ready), .Sum(s0), .Cout(co[0]), .Ovf(of[0]));
  pipelined_adder_nbit #(.WIDTH(8), .STAGES(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .A(a[7:0]), .B(b[7:0]), .Cin(cin),
    .out_valid(ov[1]), .out_ready(out_ready), .Sum(s1), .Cout(co[1]), .Ovf(of[1]));
  pipelined_adder_nbit #(.WIDTH(8), .STAGES(8)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .A(a[7:0]), .B(b[7:0]), .Cin(cin),
    .out_valid(ov[2]), .out_ready(out_ready), .Sum(s2), .Cout(co[2]), .Ovf(of[2]));
  pipelined_adder_nbit #(.WIDTH(16), .STAGES(4)) d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .A(a[15:0]), .B(b[15:0]), .Cin(cin),
    .out_valid(ov[3]), .out_ready(out_ready), .Sum(s3), .Cout(co[3]), .Ovf(of[3]));
  pipelined_adder_nbit #(.WIDTH(32), .STAGES(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[4]), .A(a), .B(b), .Cin(cin),
    .out_valid(ov[4]), .out_ready(out_ready), .Sum(s4), .Cout(co[4]), .Ovf(of[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer addition; returns {ovf, cout, sum}.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                          input logic ci);
    longint unsigned m, am, bm, full;
    logic sa, sb, ss;
    m    = (64'd1 << w) - 64'd1;
    am   = {32'd0, ai} & m;
    bm   = {32'd0, bi} & m;
    full = am + bm + {63'd0, ci};
    sa   = am[w-1];
    sb   = bm[w-1];
    ss   = full[w-1];
    return {(sa == sb) && (ss != sa), full[w], full[31:0] & m[31:0]};
  endfunction

  // Expected {out_valid, Ovf, Cout, Sum} of the 8-bit DUT for a valid result.
  function automatic logic [10:0] exp0(input logic [31:0] ai, input logic [31:0] bi, input logic ci);
    logic [33:0] r;
    r = ref_add(8, ai, bi, ci);
    return {1'b1, r[33], r[32], r[7:0]};
  endfunction

  function automatic logic [10:0] out0();
    return {ov[0], of[0], co[0], sm[0][7:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] ai, input logic [31:0] bi, input logic ci);
    in_valid = v;
    a        = ai;
    b        = bi;
    cin      = ci;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [33:0] q [ND][$];
  int          done [ND];
  logic        all_done;
  logic [33:0] e;

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {53'd0, out0()}, 64'd0);
    chk("reset_in_ready", {63'd0, ir[0]}, 64'd1);
    rst = 1'b0;

    // Basic add and latency: not visible after accept edge, visible one edge later.
    drive(1'b1, 32'h0F, 32'h01, 1'b0);
    tick();
    chk("t1_latency", {63'd0, ov[0]}, 64'd0);
    in_valid = 1'b0;
    tick();
    chk("t1_result", {53'd0, out0()}, {53'd0, 11'b1_0_0_00010000});

    // Carry across chunk boundary, then signed overflow.
    drive(1'b1, 32'hFF, 32'h01, 1'b0);
    tick();
    drive(1'b1, 32'h7F, 32'h01, 1'b0);
    tick();
    chk("t2_carry", {53'd0, out0()}, {53'd0, 11'b1_0_1_00000000});
    in_valid = 1'b0;
    tick();
    chk("t2_ovf", {53'd0, out0()}, {53'd0, 11'b1_1_0_10000000});

    // Back-to-back stream, one result per cycle in order.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 32'(i), 32'(2 * i), i[0]);
      tick();
      if (i > 0) chk("t3_stream", {53'd0, out0()}, {53'd0, exp0(32'(i - 1), 32'(2 * (i - 1)), i[0] ^ 1'b1)});
    end
    in_valid = 1'b0;
    tick();
    chk("t3_stream_last", {53'd0, out0()}, {53'd0, exp0(32'd31, 32'd62, 1'b1)});
    tick();
    chk("t3_drained", {63'd0, ov[0]}, 64'd0);

    // Backpressure: X at output, Y behind it, Z offered but must not enter.
    drive(1'b1, 32'h33, 32'h44, 1'b1);
    tick();
    drive(1'b1, 32'h80, 32'h80, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h55, 32'h55, 1'b0);
    repeat (5) begin
      #1;
      chk("t4_in_ready_low", {63'd0, ir[0]}, 64'd0);
      chk("t4_hold", {53'd0, out0()}, {53'd0, exp0(32'h33, 32'h44, 1'b1)});
      tick();
    end
    chk("t4_hold_end", {53'd0, out0()}, {53'd0, exp0(32'h33, 32'h44, 1'b1)});
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1;
    chk("t4_in_ready_high", {63'd0, ir[0]}, 64'd1);
    tick();
    chk("t4_drain_y", {53'd0, out0()}, {53'd0, 11'b1_1_1_00000000});
    tick();
    chk("t4_no_z", {63'd0, ov[0]}, 64'd0);

    // Mid-cycle reset with two results in flight.
    drive(1'b1, 32'h01, 32'h02, 1'b0);
    tick();
    drive(1'b1, 32'h03, 32'h04, 1'b0);
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_clear", {55'd0, ov[0], sm[0][7:0]}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("t5_no_stale", {63'd0, ov[0]}, 64'd0);
    end
    drive(1'b1, 32'h12, 32'h34, 1'b1);
    tick();
    chk("t5_cold_latency", {63'd0, ov[0]}, 64'd0);
    in_valid = 1'b0;
    tick();
    chk("t5_cold_result", {53'd0, out0()}, {53'd0, 11'b1_0_0_01000111});

    // Random sweep across configurations with random input gaps and backpressure.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < ND; d++) done[d] = 0;
    all_done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !all_done; cyc++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (ov[d] && out_ready) begin
          if (q[d].size() == 0) begin
            chk("sweep_spurious_output", 64'd1, 64'd0);
          end else begin
            e = q[d].pop_front();
            chk("sweep_result", {30'd0, of[d], co[d], sm[d]}, {30'd0, e});
            done[d]++;
          end
        end
        if (in_valid && ir[d]) q[d].push_back(ref_add(W[d], a, b, cin));
      end
      all_done = 1'b1;
      for (int d = 0; d < ND; d++) if (done[d] < 1000) all_done = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("sweep_complete", {63'd0, all_done}, 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
